// File: rtl/adder_stim_pkg.sv
// Package for the adder stimulus generator.
// Holds widths, LFSR constants, the FSM state type and the LFSR step function
// shared by the generator top level and the LFSR sub-module.
package adder_stim_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/lfsr_galois16.sv
// 16-bit right-shifting Galois LFSR.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, value returns to RESET_VAL
//   load     - load load_val (wins over advance)
//   load_val - value to load
//   advance  - step the LFSR once
//   value    - current LFSR state
module lfsr_galois16
    import adder_stim_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= RESET_VAL;
        end else if (load) begin
            r_value <= load_val;
        end else if (advance) begin
            r_value <= lfsr_step(r_value);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/adder_stim_gen.sv
// Stimulus generator for the 8-bit adder: emits LFSR-derived operand pairs
// with their expected modulo-256 sum over a valid/ready handshake.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   start              - begins a run from IDLE or DONE (ignored in RUN)
//   abort              - returns to IDLE on the next edge, highest priority
//   out_valid/out_ready- handshake for the triple
//   out_a, out_b       - operands
//   out_exp_sum        - (out_a + out_b) mod 256
//   txn_count          - accepted transactions in the current run
//   busy, done         - high in RUN / DONE
module adder_stim_gen
    import adder_stim_pkg::*;
#(
    parameter int unsigned       NUM_TXN = 16,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_exp_sum,
    output logic [15:0]       txn_count,
    output logic              busy,
    output logic              done
);

    // A zero seed would lock the LFSR at zero.
    localparam logic [LFSR_W-1:0] EFF_SEED = (SEED == '0) ? DEFAULT_SEED : SEED;
    localparam logic [15:0]       LAST_CNT = 16'(NUM_TXN);

    state_t r_state;
    state_t w_state_d;

    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic [15:0]       r_count;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_sum;

    logic              w_hs;
    logic              w_last;
    logic              w_load;
    logic              w_advance;
    logic              w_upd;
    logic [15:0]       w_count_d;
    logic [15:0]       w_count_inc;
    logic [LFSR_W-1:0] w_lfsr_value;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic [DATA_W-1:0] w_a_d;
    logic [DATA_W-1:0] w_b_d;
    logic [DATA_W-1:0] w_sum_d;

    lfsr_galois16 #(
        .RESET_VAL (EFF_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (EFF_SEED),
        .advance  (w_advance),
        .value    (w_lfsr_value)
    );

    assign w_hs        = (r_state == RUN) && r_valid && out_ready;
    assign w_count_inc = r_count + 16'd1;
    assign w_last      = (w_count_inc == LAST_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        if (abort) begin
            w_state_d = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (start) w_state_d = RUN;
                RUN:     if (w_hs && w_last) w_state_d = DONE;
                DONE:    if (start) w_state_d = RUN;
                default: w_state_d = IDLE;
            endcase
        end
    end

    // Datapath controls; abort suppresses both a start and a handshake.
    always_comb begin
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_count_d = r_count;
        if (!abort) begin
            if (start && (r_state != RUN)) begin
                w_load    = 1'b1;
                w_count_d = '0;
            end else if (w_hs) begin
                w_count_d = w_count_inc;
                w_advance = !w_last;
            end
        end
    end

    // The output triple must track the value the LFSR takes on this edge.
    assign w_lfsr_next = w_load ? EFF_SEED : lfsr_step(w_lfsr_value);
    assign w_upd       = w_load || w_advance;
    assign w_a_d       = w_lfsr_next[DATA_W-1:0];
    assign w_b_d       = w_lfsr_next[LFSR_W-1:DATA_W];
    assign w_sum_d     = w_a_d + w_b_d;  // carry dropped to match the DUT

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            r_valid <= (w_state_d == RUN);
            r_busy  <= (w_state_d == RUN);
            r_done  <= (w_state_d == DONE);
            r_count <= w_count_d;
            if (w_upd) begin
                r_a   <= w_a_d;
                r_b   <= w_b_d;
                r_sum <= w_sum_d;
            end
        end
    end

    assign out_valid   = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign txn_count   = r_count;
    assign out_a       = r_a;
    assign out_b       = r_b;
    assign out_exp_sum = r_sum;

endmodule

// File: tb/tb_adder_stim_gen.sv
module tb_adder_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, out_ready;
    logic        out_valid, busy, done;
    logic [7:0]  out_a, out_b, out_exp_sum;
    logic [15:0] txn_count;

    logic        start2, abort2, out_ready2;
    logic        out_valid2, busy2, done2;
    logic [7:0]  out_a2, out_b2, out_exp_sum2;
    logic [15:0] txn_count2;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    adder_stim_gen #(
        .NUM_TXN (16),
        .SEED    (16'hACE1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_exp_sum (out_exp_sum),
        .txn_count   (txn_count),
        .busy        (busy),
        .done        (done)
    );

    adder_stim_gen #(
        .NUM_TXN (1),
        .SEED    (16'h0000)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start2),
        .abort       (abort2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .out_a       (out_a2),
        .out_b       (out_b2),
        .out_exp_sum (out_exp_sum2),
        .txn_count   (txn_count2),
        .busy        (busy2),
        .done        (done2)
    );

    function automatic logic [15:0] m_next(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Model the whole run and queue the expected triples.
    task automatic push_run(input logic [15:0] seed, input int n);
        logic [15:0] v;
        logic [7:0]  a, b, s;
        v = seed;
        for (int i = 0; i < n; i++) begin
            a = v[7:0];
            b = v[15:8];
            s = a + b;
            exp_q.push_back({a, b, s});
            v = m_next(v);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of a run: valid must be up; a handshake pops the scoreboard.
    task automatic hs_step(input string tag);
        logic [23:0] e;
        chk({tag, "/valid"}, 32'(out_valid), 32'd1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL %s/extra: observed unexpected triple %0h expected none",
                       tag, {out_a, out_b, out_exp_sum});
            end else begin
                e = exp_q.pop_front();
                chk({tag, "/triple"}, 32'({out_a, out_b, out_exp_sum}), 32'(e));
            end
        end
        tick();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "/valid"}, 32'(out_valid), 32'd0);
        chk({tag, "/triple"}, 32'({out_a, out_b, out_exp_sum}), 32'd0);
        chk({tag, "/count"}, 32'(txn_count), 32'd0);
        chk({tag, "/busy"}, 32'(busy), 32'd0);
        chk({tag, "/done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        start2     = 1'b0;
        abort2     = 1'b0;
        out_ready2 = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        chk_cleared("reset");
        chk("reset1/valid", 32'(out_valid2), 32'd0);
        chk("reset1/triple", 32'({out_a2, out_b2, out_exp_sum2}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle/valid", 32'(out_valid), 32'd0);
        end

        // Default run with the consumer always ready
        out_ready = 1'b1;
        start = 1'b1;
        push_run(16'hACE1, 16);
        tick();
        start = 1'b0;
        chk("run/txn0", 32'({out_a, out_b, out_exp_sum}), 32'hE1AC8D);
        chk("run/busy", 32'(busy), 32'd1);
        hs_step("run");
        chk("run/txn1", 32'({out_a, out_b, out_exp_sum}), 32'h70E252);
        for (int i = 1; i < 16; i++) hs_step("run");
        chk("run/done", 32'(done), 32'd1);
        chk("run/valid_end", 32'(out_valid), 32'd0);
        chk("run/busy_end", 32'(busy), 32'd0);
        chk("run/count", 32'(txn_count), 32'd16);
        chk("run/queue", 32'(exp_q.size()), 32'd0);

        // Backpressure at txn 0, then restart from DONE
        out_ready = 1'b0;
        start = 1'b1;
        push_run(16'hACE1, 16);
        tick();
        start = 1'b0;
        chk("bp/done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp/hold", 32'({out_a, out_b, out_exp_sum}), 32'hE1AC8D);
            chk("bp/count", 32'(txn_count), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        hs_step("bp");
        chk("bp/txn1", 32'({out_a, out_b, out_exp_sum}), 32'h70E252);
        chk("bp/count1", 32'(txn_count), 32'd1);

        // start mid-run must not disturb the sequence
        hs_step("mid");
        start = 1'b1;
        hs_step("mid_start");
        start = 1'b0;
        hs_step("mid");
        hs_step("mid");
        chk("mid/count5", 32'(txn_count), 32'd5);

        // abort together with a handshake: abort wins, count holds
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk("abort/valid", 32'(out_valid), 32'd0);
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/done", 32'(done), 32'd0);
        chk("abort/count", 32'(txn_count), 32'd5);
        tick();
        chk("abort/idle", 32'(out_valid), 32'd0);

        // Re-start reproduces the sequence; then async reset at txn_count 7
        start = 1'b1;
        push_run(16'hACE1, 16);
        tick();
        start = 1'b0;
        chk("restart/txn0", 32'({out_a, out_b, out_exp_sum}), 32'hE1AC8D);
        chk("restart/count", 32'(txn_count), 32'd0);
        for (int i = 0; i < 7; i++) hs_step("restart");
        chk("restart/count7", 32'(txn_count), 32'd7);
        #3 rst_n = 1'b0;
        #1;
        chk_cleared("async_rst");
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        tick();
        start = 1'b1;
        push_run(16'hACE1, 16);
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) hs_step("post_rst");
        chk("post_rst/done", 32'(done), 32'd1);
        chk("post_rst/count", 32'(txn_count), 32'd16);

        // NUM_TXN = 1, SEED = 0 instance
        out_ready2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("one/triple", 32'({out_a2, out_b2, out_exp_sum2}), 32'hE1AC8D);
        chk("one/valid", 32'(out_valid2), 32'd1);
        tick();
        chk("one/done", 32'(done2), 32'd1);
        chk("one/count", 32'(txn_count2), 32'd1);
        chk("one/valid_end", 32'(out_valid2), 32'd0);
        chk("one/busy_end", 32'(busy2), 32'd0);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("one2/valid", 32'(out_valid2), 32'd1);
        chk("one2/done_clr", 32'(done2), 32'd0);
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        chk("one2/valid_abort", 32'(out_valid2), 32'd0);
        chk("one2/done_abort", 32'(done2), 32'd0);
        chk("one2/busy_abort", 32'(busy2), 32'd0);
        chk("one2/count_abort", 32'(txn_count2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
